// File: rtl/tile_walker_pkg.sv
// Shared types and constants for the tile walker: fixed-point widths, tile size,
// the upstream setup structs and the emitted fragment.
package tile_walker_pkg;

    localparam int FX_TOTAL_BITS   = 16;
    localparam int FX_FRAC_BITS    = 4;
    localparam int ACC_W           = FX_TOTAL_BITS * 2;
    localparam int TILE_WIDTH_BITS = 4;
    localparam int TILE_DIM        = 1 << TILE_WIDTH_BITS;
    localparam int TILE_COORD_BITS = 8;
    localparam int PIX_W           = TILE_COORD_BITS + TILE_WIDTH_BITS;
    localparam int COLOR_BITS      = 24;

    typedef struct packed {
        logic signed [FX_TOTAL_BITS-1:0] x;
        logic signed [FX_TOTAL_BITS-1:0] y;
        logic signed [FX_TOTAL_BITS-1:0] z;
    } coord_3d_t;

    typedef struct packed {
        logic [COLOR_BITS-1:0]      color;
        logic [TILE_COORD_BITS-1:0] tile_x;
        logic [TILE_COORD_BITS-1:0] tile_y;
    } metadata_t;

    typedef struct packed {
        logic [PIX_W-1:0]                pix_x;
        logic [PIX_W-1:0]                pix_y;
        logic signed [FX_TOTAL_BITS-1:0] z;
        logic [COLOR_BITS-1:0]           color;
        logic                            covered;
        logic                            last;
    } fragment_t;

    // One-pixel step of a 12.4 gradient expressed in the 8-fraction-bit accumulator domain.
    function automatic logic [ACC_W-1:0] step_of(input logic [FX_TOTAL_BITS-1:0] d);
        return {{(ACC_W-FX_TOTAL_BITS){d[FX_TOTAL_BITS-1]}}, d} << FX_FRAC_BITS;
    endfunction

endpackage

// File: rtl/edge_stepper.sv
// One incremental accumulator with a row-start copy; used for each edge function and for depth.
module edge_stepper
    import tile_walker_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [ACC_W-1:0] init_i,
    input  logic [ACC_W-1:0] col_step_i,
    input  logic [ACC_W-1:0] row_step_i,
    input  logic             col_adv_i,
    input  logic             row_adv_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] row_q, row_d;
    logic [ACC_W-1:0] row_next;

    // A row step restarts from the row-start copy so column error never accumulates across rows.
    always_comb begin
        row_next = row_q + row_step_i;
        acc_d    = acc_q;
        row_d    = row_q;
        if (load_i) begin
            acc_d = init_i;
            row_d = init_i;
        end else if (row_adv_i) begin
            acc_d = row_next;
            row_d = row_next;
        end else if (col_adv_i) begin
            acc_d = acc_q + col_step_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            row_q <= '0;
        end else begin
            acc_q <= acc_d;
            row_q <= row_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/tile_walker.sv
// Walks a TILE_DIM x TILE_DIM tile in raster order, emitting one fragment per pixel.
// Optional macro RASTER_BOTH_WINDINGS_EN: also treat all-edges-nonpositive as covered.
module tile_walker
    import tile_walker_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vld_in,
    output logic                     rdy_in,
    input  coord_3d_t                in_abs_pos,
    input  coord_3d_t                in_delta_0,
    input  coord_3d_t                in_delta_1,
    input  coord_3d_t                in_delta_2,
    input  logic signed [ACC_W-1:0]  in_edge_0,
    input  logic signed [ACC_W-1:0]  in_edge_1,
    input  logic signed [ACC_W-1:0]  in_edge_2,
    input  metadata_t                in_metadata,
    input  logic signed [FX_TOTAL_BITS-1:0] in_dzdx,
    input  logic signed [FX_TOTAL_BITS-1:0] in_dzdy,
    input  logic signed [ACC_W-1:0]  in_z_current,
    input  logic                     rdy_out,
    output logic                     vld_out,
    output fragment_t                out_frag
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WALK = 1'b1;
    localparam logic [TILE_WIDTH_BITS-1:0] TILE_MAX = '1;

    logic [0:0]                 state_q, state_d;
    logic [TILE_WIDTH_BITS-1:0] col_q, col_d, row_q, row_d;
    metadata_t                  meta_q, meta_d;
    logic [3:0][ACC_W-1:0]      col_step_q, col_step_d, row_step_q, row_step_d;

    coord_3d_t [2:0]       delta;
    logic [3:0][ACC_W-1:0] init_val;
    logic [3:0][ACC_W-1:0] acc;
    logic load, fire, last_px, col_adv, row_adv, covered, all_pos;

    assign delta    = {in_delta_2, in_delta_1, in_delta_0};
    assign init_val = {in_z_current, in_edge_2, in_edge_1, in_edge_0};

    assign load    = (state_q == ST_IDLE) && vld_in;
    assign fire    = (state_q == ST_WALK) && rdy_out;
    assign last_px = (col_q == TILE_MAX) && (row_q == TILE_MAX);
    assign col_adv = fire && (col_q != TILE_MAX);
    assign row_adv = fire && (col_q == TILE_MAX) && !last_px;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        meta_d     = meta_q;
        col_step_d = col_step_q;
        row_step_d = row_step_q;
        if (load) begin
            state_d = ST_WALK;
            col_d   = '0;
            row_d   = '0;
            meta_d  = in_metadata;
            for (int i = 0; i < 3; i++) begin
                col_step_d[i] = step_of(delta[i].y);
                row_step_d[i] = ACC_W'(0) - step_of(delta[i].x);
            end
            col_step_d[3] = step_of(in_dzdx);
            row_step_d[3] = step_of(in_dzdy);
        end else if (fire) begin
            if (last_px) begin
                state_d = ST_IDLE;
            end else if (col_q == TILE_MAX) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            meta_q     <= '0;
            col_step_q <= '0;
            row_step_q <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            meta_q     <= meta_d;
            col_step_q <= col_step_d;
            row_step_q <= row_step_d;
        end
    end

    // Instances 0..2 are the edge functions, instance 3 is depth.
    for (genvar g = 0; g < 4; g++) begin : g_step
        edge_stepper u_step (
            .clk_i      (clk),
            .rst_i      (rst),
            .load_i     (load),
            .init_i     (init_val[g]),
            .col_step_i (col_step_q[g]),
            .row_step_i (row_step_q[g]),
            .col_adv_i  (col_adv),
            .row_adv_i  (row_adv),
            .acc_o      (acc[g])
        );
    end

    assign all_pos = ~(acc[0][ACC_W-1] | acc[1][ACC_W-1] | acc[2][ACC_W-1]);

`ifdef RASTER_BOTH_WINDINGS_EN
    logic all_neg;
    assign all_neg = (acc[0][ACC_W-1] || (acc[0] == '0)) &&
                     (acc[1][ACC_W-1] || (acc[1] == '0)) &&
                     (acc[2][ACC_W-1] || (acc[2] == '0));
    assign covered = all_pos | all_neg;
`else
    assign covered = all_pos;
`endif

    // Fragment is zero outside a walk so reset and idle present a clean bus.
    always_comb begin
        out_frag = '0;
        if (state_q == ST_WALK) begin
            out_frag.pix_x   = {meta_q.tile_x, col_q};
            out_frag.pix_y   = {meta_q.tile_y, row_q};
            out_frag.z       = acc[3][FX_TOTAL_BITS+FX_FRAC_BITS-1:FX_FRAC_BITS];
            out_frag.color   = meta_q.color;
            out_frag.covered = covered;
            out_frag.last    = last_px;
        end
    end

    assign vld_out = (state_q == ST_WALK);
    assign rdy_in  = (state_q == ST_IDLE);

    logic unused_bits;
    assign unused_bits = ^{in_abs_pos, in_delta_0.z, in_delta_1.z, in_delta_2.z,
                           acc[3][ACC_W-1:FX_TOTAL_BITS+FX_FRAC_BITS], acc[3][FX_FRAC_BITS-1:0],
                           acc[0][ACC_W-2:0], acc[1][ACC_W-2:0], acc[2][ACC_W-2:0]};

endmodule

// File: tb/tb_tile_walker.sv
// Self-checking bench for tile_walker against a direct edge/plane-equation reference model.
module tb_tile_walker;
    import tile_walker_pkg::*;

    localparam int TD = TILE_DIM;
    localparam int NPIX = TD * TD;

    logic clk = 1'b0;
    logic rst, vld_in, rdy_in, rdy_out, vld_out;
    coord_3d_t in_abs_pos, in_delta_0, in_delta_1, in_delta_2;
    logic signed [ACC_W-1:0] in_edge_0, in_edge_1, in_edge_2, in_z_current;
    metadata_t in_metadata;
    logic signed [FX_TOTAL_BITS-1:0] in_dzdx, in_dzdy;
    fragment_t out_frag;

    always #5 clk = ~clk;

    tile_walker dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy_in),
        .in_abs_pos(in_abs_pos), .in_delta_0(in_delta_0), .in_delta_1(in_delta_1),
        .in_delta_2(in_delta_2), .in_edge_0(in_edge_0), .in_edge_1(in_edge_1),
        .in_edge_2(in_edge_2), .in_metadata(in_metadata), .in_dzdx(in_dzdx),
        .in_dzdy(in_dzdy), .in_z_current(in_z_current), .rdy_out(rdy_out),
        .vld_out(vld_out), .out_frag(out_frag)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference tile: vertices in 12.4 pixel units, depth plane in accumulator units.
    longint vx[3], vy[3];
    longint z0, dzdx, dzdy;
    int tx, ty;
    logic [COLOR_BITS-1:0] color;
    logic [15:0] z_seen[NPIX];
    logic [PIX_W-1:0] first_pix_x;

    function automatic longint edge_at(int i, longint px, longint py);
        int j = (i + 1) % 3;
        return (px - vx[i]) * (vy[j] - vy[i]) - (py - vy[i]) * (vx[j] - vx[i]);
    endfunction

    function automatic bit model_cov(int col, int row);
        longint px = longint'(tx * TD + col) * 16;
        longint py = longint'(ty * TD + row) * 16;
        longint e0 = edge_at(0, px, py);
        longint e1 = edge_at(1, px, py);
        longint e2 = edge_at(2, px, py);
        bit pos = (e0 >= 0) && (e1 >= 0) && (e2 >= 0);
        bit neg = (e0 <= 0) && (e1 <= 0) && (e2 <= 0);
`ifdef RASTER_BOTH_WINDINGS_EN
        return pos || neg;
`else
        if (neg && !pos) return 1'b0;
        return pos;
`endif
    endfunction

    function automatic fragment_t model_frag(int k);
        fragment_t f;
        int col = k % TD;
        int row = k / TD;
        longint za = z0 + longint'(col) * dzdx * 16 + longint'(row) * dzdy * 16;
        logic [63:0] zl = za;
        f.pix_x   = PIX_W'(tx * TD + col);
        f.pix_y   = PIX_W'(ty * TD + row);
        f.z       = zl[FX_TOTAL_BITS+FX_FRAC_BITS-1:FX_FRAC_BITS];
        f.color   = color;
        f.covered = model_cov(col, row);
        f.last    = (k == NPIX - 1);
        return f;
    endfunction

    function automatic logic [NPIX-1:0] model_mask();
        logic [NPIX-1:0] m = '0;
        for (int k = 0; k < NPIX; k++) m[k] = model_cov(k % TD, k / TD);
        return m;
    endfunction

    // Upstream setup from integer pixel vertices with a flat depth plane solved exactly.
    task automatic set_tri(input int x0, y0, zz0, x1, y1, zz1, x2, y2, zz2, input int tx_i, ty_i);
        longint area, ox, oy;
        vx[0] = x0 * 16; vy[0] = y0 * 16;
        vx[1] = x1 * 16; vy[1] = y1 * 16;
        vx[2] = x2 * 16; vy[2] = y2 * 16;
        tx = tx_i; ty = ty_i;
        area = longint'(x1 - x0) * (y2 - y0) - longint'(x2 - x0) * (y1 - y0);
        dzdx = (longint'(zz1 - zz0) * (y2 - y0) - longint'(zz2 - zz0) * (y1 - y0)) * 16 / area;
        dzdy = (longint'(zz2 - zz0) * (x1 - x0) - longint'(zz1 - zz0) * (x2 - x0)) * 16 / area;
        ox = longint'(tx * TD); oy = longint'(ty * TD);
        z0 = longint'(zz0) * 256 + dzdx * 16 * (ox - x0) + dzdy * 16 * (oy - y0);
        color = 24'($urandom);
    endtask

    function automatic coord_3d_t delta_of(int i);
        coord_3d_t d;
        int j = (i + 1) % 3;
        d.x = 16'(vx[j] - vx[i]);
        d.y = 16'(vy[j] - vy[i]);
        d.z = 16'($urandom);
        return d;
    endfunction

    task automatic drive_setup();
        longint ox = longint'(tx * TD) * 16;
        longint oy = longint'(ty * TD) * 16;
        in_abs_pos.x = 16'(ox); in_abs_pos.y = 16'(oy); in_abs_pos.z = '0;
        in_delta_0 = delta_of(0); in_delta_1 = delta_of(1); in_delta_2 = delta_of(2);
        in_edge_0 = 32'(edge_at(0, ox, oy));
        in_edge_1 = 32'(edge_at(1, ox, oy));
        in_edge_2 = 32'(edge_at(2, ox, oy));
        in_metadata.color = color; in_metadata.tile_x = 8'(tx); in_metadata.tile_y = 8'(ty);
        in_dzdx = 16'(dzdx); in_dzdy = 16'(dzdy); in_z_current = 32'(z0);
    endtask

    task automatic scramble();
        in_abs_pos = 48'({$urandom, $urandom});
        in_delta_0 = 48'({$urandom, $urandom});
        in_delta_1 = 48'({$urandom, $urandom});
        in_delta_2 = 48'({$urandom, $urandom});
        in_edge_0 = $urandom; in_edge_1 = $urandom; in_edge_2 = $urandom;
        in_metadata = 40'({$urandom, $urandom});
        in_dzdx = 16'($urandom); in_dzdy = 16'($urandom); in_z_current = $urandom;
    endtask

    // Hands one tile upstream, then checks every presented fragment until the tile
    // completes or reset is applied when pixel rst_at is on the bus.
    task automatic run_tile(input bit stall, input int rst_at, output logic [NPIX-1:0] mask);
        int t, k, cyc;
        bit held;
        fragment_t cur, prev;
        mask = '0; t = 0; held = 1'b0; prev = '0;
        while (rdy_in !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("rdy_in_idle", rdy_in, 1'b1);
        drive_setup();
        vld_in = 1'b1;
        @(posedge clk); #1;
        scramble();
        k = 0; cyc = 0;
        while (k < NPIX && cyc < 4000) begin
            rdy_out = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k >= NPIX - 4 || k == rst_at) vld_in = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("rst_vld_out", vld_out, 1'b0);
                check("rst_rdy_in", rdy_in, 1'b1);
                check("rst_frag", out_frag, '0);
                return;
            end
            @(negedge clk);
            cur = out_frag;
            check("walk_hs", {vld_out, rdy_in}, 2'b10);
            check($sformatf("frag[%0d]", k), cur, model_frag(k));
            if (held) check("stall_hold", cur, prev);
            @(posedge clk); #1;
            if (rdy_out) begin
                mask[k] = cur.covered;
                z_seen[k] = cur.z;
                if (k == 0) first_pix_x = cur.pix_x;
                k++;
                held = 1'b0;
            end else begin
                prev = cur;
                held = 1'b1;
            end
            cyc++;
        end
        check("tile_frag_count", k, NPIX);
        @(negedge clk);
        check("end_hs", {vld_out, rdy_in}, 2'b01);
    endtask

    logic [NPIX-1:0] m_ref, m_dut;
    logic signed [15:0] r16;

    initial begin
        rst = 1'b1; vld_in = 1'b0; rdy_out = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_vld_out", vld_out, 1'b0);
        check("reset_rdy_in", rdy_in, 1'b1);
        check("reset_frag", out_frag, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reference triangle, free-flowing downstream.
        set_tri(1, 14, 512, 12, 15, 512, 7, 2, 512, 0, 0);
        m_ref = model_mask();
        run_tile(1'b0, -1, m_dut);
        check("cov_7_10", m_dut[10*TD+7], 1'b1);
        check("cov_0_0", m_dut[0], 1'b0);
        check("z_7_10", z_seen[10*TD+7], 16'h2000);
        check("cov_set", m_dut, m_ref);

        // Same triangle under random back-pressure.
        set_tri(1, 14, 512, 12, 15, 512, 7, 2, 512, 0, 0);
        run_tile(1'b1, -1, m_dut);
        check("stall_cov_set", m_dut, m_ref);

        // Opposite winding.
        set_tri(1, 14, 512, 7, 2, 512, 12, 15, 512, 0, 0);
        run_tile(1'b0, -1, m_dut);
`ifdef RASTER_BOTH_WINDINGS_EN
        check("swap_cov_set", m_dut, m_ref);
`else
        check("swap_cov_set", m_dut, '0);
`endif

        // Reset mid-walk, then a clean tile.
        set_tri(1, 14, 512, 12, 15, 512, 7, 2, 512, 0, 0);
        run_tile(1'b1, 37, m_dut);
        set_tri(1, 14, 512, 12, 15, 512, 7, 2, 512, 0, 0);
        run_tile(1'b0, -1, m_dut);
        check("post_rst_cov_set", m_dut, m_ref);

        // Offset tile with a depth gradient along y.
        set_tri(1, 1, 256, 1, 20, 1024, 2, 1, 256, 2, 0);
        run_tile(1'b0, -1, m_dut);
        check("first_pix_x", first_pix_x, PIX_W'(2 * TD));
        check("z_origin", z_seen[0], 16'd3450);
        check("z_row_step", 16'(z_seen[TD] - z_seen[0]), 16'd646);

        // Random triangles, depth planes with wrap, random stalls.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 3; i++) begin
                vx[i] = $urandom_range(0, 80 * 16);
                vy[i] = $urandom_range(0, 80 * 16);
            end
            tx = $urandom_range(0, 3); ty = $urandom_range(0, 3);
            z0 = longint'($urandom);
            r16 = 16'($urandom); dzdx = r16;
            r16 = 16'($urandom); dzdy = r16;
            color = 24'($urandom);
            m_ref = model_mask();
            run_tile(1'($urandom_range(0, 1)), -1, m_dut);
            check("rand_cov_set", m_dut, m_ref);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
